// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: instruction- and data-cache controllers share a
// single memory port. Ownership is granted per burst (held while req stays
// high), alternates on simultaneous requests, and is followed by a short drain
// window so that read data already in flight still reaches the previous owner.
module mem_arbiter #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DRAIN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          i_rd,
    input  logic          i_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    input  logic          d_req,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          mem_stall,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          i_gnt,
    output logic          d_gnt,
    output logic          i_stall,
    output logic          d_stall,
    output logic [DW-1:0] i_rdata,
    output logic [DW-1:0] d_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        DRAIN_ST = 2'd3
    } state_t;

    localparam logic       SIDE_I     = 1'b0;
    localparam logic       SIDE_D     = 1'b1;
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN - 1);

    state_t     state_reg, state_next;
    logic [2:0] drain_cnt_reg, drain_cnt_next;
    logic       last_served_reg, last_served_next;
    logic       owner_reg, owner_next;

    // State, drain counter, fairness bit and read-data owner registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            drain_cnt_reg   <= 3'd0;
            last_served_reg <= SIDE_I;
            owner_reg       <= SIDE_I;
        end else begin
            state_reg       <= state_next;
            drain_cnt_reg   <= drain_cnt_next;
            last_served_reg <= last_served_next;
            owner_reg       <= owner_next;
        end
    end

    // Next-state logic: arbitration in IDLE, burst hold in OWN_x, drain countdown
    always_comb begin
        state_next       = state_reg;
        drain_cnt_next   = drain_cnt_reg;
        last_served_next = last_served_reg;
        owner_next       = owner_reg;
        unique case (state_reg)
            IDLE: begin
                // A stalled memory freezes arbitration entirely
                if (!mem_stall) begin
                    if (i_req && d_req) begin
                        if (last_served_reg == SIDE_I) begin
                            state_next       = OWN_D;
                            last_served_next = SIDE_D;
                            owner_next       = SIDE_D;
                        end else begin
                            state_next       = OWN_I;
                            last_served_next = SIDE_I;
                            owner_next       = SIDE_I;
                        end
                    end else if (i_req) begin
                        state_next       = OWN_I;
                        last_served_next = SIDE_I;
                        owner_next       = SIDE_I;
                    end else if (d_req) begin
                        state_next       = OWN_D;
                        last_served_next = SIDE_D;
                        owner_next       = SIDE_D;
                    end
                end
            end
            OWN_I: begin
                if (!i_req) begin
                    state_next     = DRAIN_ST;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            OWN_D: begin
                if (!d_req) begin
                    state_next     = DRAIN_ST;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            DRAIN_ST: begin
                if (drain_cnt_reg == 3'd0) begin
                    state_next = IDLE;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory-side mux: forward the owner's beat; strobes need the owner's req
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_reg == OWN_I) begin
            mem_wr    = i_req & i_wr;
            mem_rd    = i_req & i_rd & ~i_wr;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
        end else if (state_reg == OWN_D) begin
            mem_wr    = d_req & d_wr;
            mem_rd    = d_req & d_rd & ~d_wr;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign i_gnt = (state_reg == OWN_I);
    assign d_gnt = (state_reg == OWN_D);

    assign i_stall = (i_req & ~i_gnt) | (i_gnt & mem_stall);
    assign d_stall = (d_req & ~d_gnt) | (d_gnt & mem_stall);

    // Read data goes only to the recorded owner; blanked while reset is held
    assign i_rdata = (rst && owner_reg == SIDE_I) ? mem_rdata : '0;
    assign d_rdata = (rst && owner_reg == SIDE_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, every cycle compared against a burst-level reference model.
module tb_mem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DRAIN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 0, i_rd = 0, i_wr = 0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_wdata = '0;
    logic          d_req = 0, d_rd = 0, d_wr = 0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          mem_stall = 0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          i_gnt, d_gnt, i_stall, d_stall;
    logic [DW-1:0] i_rdata, d_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .DRAIN(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .i_stall(i_stall), .d_stall(d_stall),
        .i_rdata(i_rdata), .d_rdata(d_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the port (0 none, 1 I, 2 D), how many drain
    // cycles are still to run, who won last, and who receives read data.
    int m_holder;
    int m_drain_left;
    int m_last;
    int m_rd_side;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holder     = 0;
        m_drain_left = 0;
        m_last       = 1;
        m_rd_side    = 1;
    endtask

    // Advance the model by one rising edge using the currently driven inputs
    task automatic model_clock();
        int pick;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_holder != 0) begin
            if ((m_holder == 1 && !i_req) || (m_holder == 2 && !d_req)) begin
                m_holder     = 0;
                m_drain_left = DRAIN;
            end
        end else if (m_drain_left > 0) begin
            m_drain_left--;
        end else if (!mem_stall) begin
            pick = 0;
            if (i_req && d_req) pick = (m_last == 1) ? 2 : 1;
            else if (i_req)     pick = 1;
            else if (d_req)     pick = 2;
            if (pick != 0) begin
                m_holder  = pick;
                m_last    = pick;
                m_rd_side = pick;
            end
        end
    endtask

    // Compare every output against what the model predicts for this cycle
    task automatic check_outputs();
        logic          e_ig, e_dg, s_req, s_rd, s_wr;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        e_ig    = (m_holder == 1);
        e_dg    = (m_holder == 2);
        s_req   = e_ig ? i_req   : e_dg ? d_req   : 1'b0;
        s_rd    = e_ig ? i_rd    : e_dg ? d_rd    : 1'b0;
        s_wr    = e_ig ? i_wr    : e_dg ? d_wr    : 1'b0;
        s_addr  = e_ig ? i_addr  : e_dg ? d_addr  : '0;
        s_wdata = e_ig ? i_wdata : e_dg ? d_wdata : '0;
        check_eq("i_gnt",     32'(i_gnt),     32'(e_ig));
        check_eq("d_gnt",     32'(d_gnt),     32'(e_dg));
        check_eq("mem_wr",    32'(mem_wr),    32'(s_req & s_wr));
        check_eq("mem_rd",    32'(mem_rd),    32'(s_req & s_rd & ~s_wr));
        check_eq("mem_addr",  32'(mem_addr),  32'(s_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(s_wdata));
        check_eq("i_stall",   32'(i_stall),   32'((i_req & ~e_ig) | (e_ig & mem_stall)));
        check_eq("d_stall",   32'(d_stall),   32'((d_req & ~e_dg) | (e_dg & mem_stall)));
        check_eq("i_rdata",   32'(i_rdata),   (rst && m_rd_side == 1) ? 32'(mem_rdata) : 32'd0);
        check_eq("d_rdata",   32'(d_rdata),   (rst && m_rd_side == 2) ? 32'(mem_rdata) : 32'd0);
    endtask

    // Called at a falling edge after inputs are set: check, clock, return at next falling edge
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req = 0; i_rd = 0; i_wr = 0; i_addr = '0; i_wdata = '0;
        d_req = 0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        mem_stall = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        step();
        step();
        rst = 1;
    endtask

    initial begin
        model_reset();
        clear_inputs();
        @(negedge clk);
        do_reset();

        // Both request right after reset: D wins; then D bursts and drains
        i_req = 1; d_req = 1;
        step();
        #1 check_eq("both_req_dgnt", 32'(d_gnt), 32'd1);
        check_eq("both_req_ignt", 32'(i_gnt), 32'd0);
        d_wr = 1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
        #1;
        check_eq("dwr_mem_wr",    32'(mem_wr),    32'd1);
        check_eq("dwr_mem_addr",  32'(mem_addr),  32'h1234);
        check_eq("dwr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check_eq("dwr_i_stall",   32'(i_stall),   32'd1);
        step();
        d_rd = 1;
        #1 check_eq("rdwr_mem_wr", 32'(mem_wr), 32'd1);
        check_eq("rdwr_mem_rd", 32'(mem_rd), 32'd0);
        step();
        d_req = 0; d_rd = 0; d_wr = 0;
        step();
        mem_rdata = 16'h5A5A;
        #1 check_eq("drain_d_rdata", 32'(d_rdata), 32'h5A5A);
        check_eq("drain_i_rdata", 32'(i_rdata), 32'd0);
        check_eq("drain1_ignt",   32'(i_gnt),   32'd0);
        step();
        check_eq("drain2_ignt", 32'(i_gnt), 32'd0);
        step();
        check_eq("idle_ignt", 32'(i_gnt), 32'd0);
        step();
        check_eq("after_drain_ignt", 32'(i_gnt), 32'd1);

        // Stalled memory in IDLE blocks arbitration
        i_req = 0;
        for (int k = 0; k < DRAIN + 2; k++) step();
        mem_stall = 1; i_req = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stall_no_gnt", 32'(i_gnt), 32'd0);
        end
        mem_stall = 0;
        step();
        check_eq("stall_release_gnt", 32'(i_gnt), 32'd1);

        // Reset asserted in the middle of an I burst
        i_wr = 1; i_addr = 16'h00F0; i_wdata = 16'h1111; mem_rdata = 16'h7777;
        step();
        rst = 0;
        model_reset();
        #1 check_eq("rst_ignt",    32'(i_gnt),    32'd0);
        check_eq("rst_mem_wr",   32'(mem_wr),   32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_i_rdata",  32'(i_rdata),  32'd0);
        step();
        rst = 1;
        d_req = 1;
        step();
        check_eq("post_rst_dgnt", 32'(d_gnt), 32'd1);

        // Random traffic against the model
        clear_inputs();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) i_req = ~i_req;
            if ($urandom_range(0, 3) == 0) d_req = ~d_req;
            i_rd = 1'($urandom); i_wr = 1'($urandom);
            d_rd = 1'($urandom); d_wr = 1'($urandom);
            i_addr = AW'($urandom); i_wdata = DW'($urandom);
            d_addr = AW'($urandom); d_wdata = DW'($urandom);
            mem_stall = ($urandom_range(0, 3) == 0);
            mem_rdata = DW'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 0;
                model_reset();
                step();
                rst = 1;
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 16, is the memory address width in bits.
REQ-002 Parameter DW, default 16, is the memory data width in bits.
REQ-003 Parameter DRAIN, default 2, is the number of post-release cycles reserved for in-flight read data (range 1-7).
REQ-004 The ports SHALL be, in order:
- clk  in  1  clock; the block has exactly one clock.
- rst  in  1  reset; asynchronous, active-low.
- i_req  in  1  instruction-cache controller requests memory ownership.
- i_rd, i_wr  in  1 each  instruction-side per-beat read / write strobes.
- i_addr  in  AW  instruction-side beat address.
- i_wdata  in  DW  instruction-side write data.
- d_req, d_rd, d_wr, d_addr, d_wdata  in  as above  data-cache controller equivalents.
- mem_stall  in  1  shared memory cannot accept a beat this cycle.
- mem_rdata  in  DW  shared memory read data.
- mem_rd, mem_wr  out  1 each  forwarded strobes.
- mem_addr  out  AW  forwarded address.
- mem_wdata  out  DW  forwarded write data.
- i_gnt, d_gnt  out  1 each  ownership grant.
- i_stall, d_stall  out  1 each  requester must hold its current beat.
- i_rdata, d_rdata  out  DW  routed read data.

Function
REQ-005 The state machine SHALL have exactly four states: IDLE, OWN_I, OWN_D, DRAIN_ST.
REQ-006 i_gnt SHALL be 1 iff state==OWN_I; d_gnt SHALL be 1 iff state==OWN_D (Moore, registered state).
REQ-007 In IDLE with mem_stall=0: only i_req -> OWN_I; only d_req -> OWN_D; both -> the side not recorded in last_served; neither -> stay.
REQ-008 In IDLE with mem_stall=1, no transition SHALL occur.
REQ-009 Grant latency SHALL be exactly one cycle from the first sampled edge with req=1 in IDLE and mem_stall=0.
REQ-010 On entering OWN_x, last_served SHALL be set to x.
REQ-011 OWN_x SHALL persist while x_req=1; x_req=0 SHALL move to DRAIN_ST and load drain_cnt with DRAIN-1.
REQ-012 In DRAIN_ST, drain_cnt SHALL decrement each cycle; at drain_cnt==0 the next state SHALL be IDLE.
REQ-013 During OWN_x, mem_addr/mem_wdata SHALL equal x_addr/x_wdata, mem_wr=x_wr, and mem_rd=x_rd & ~x_wr (write wins).
REQ-014 Outside OWN_I/OWN_D, mem_rd=mem_wr=0, mem_addr=0 and mem_wdata=0.
REQ-015 A rdata owner register SHALL track the side last granted; i_rdata=mem_rdata when the owner is I, else 0; d_rdata likewise for D. The owner register is unchanged in DRAIN_ST and IDLE.
REQ-016 x_stall SHALL be (x_req & ~x_gnt) | (x_gnt & mem_stall), computed combinationally.
REQ-017 A request from the non-owner SHALL neither preempt nor alter the current ownership.
REQ-018 Strobes asserted by a side with x_req=0 SHALL be ignored.

Reset
REQ-019 rst=0 SHALL immediately force state=IDLE, drain_cnt=0, last_served=I, and rdata owner=I, including in the middle of a transaction.
REQ-020 While in reset: all gnt, mem_rd, mem_wr, mem_addr, mem_wdata, and rdata outputs SHALL be 0; x_stall SHALL follow REQ-016.

Verification
REQ-021 After reset, drive both reqs in the same cycle -> d_gnt=1 the next cycle; drop d_req -> 2 drain cycles -> IDLE -> i_gnt=1.
REQ-022 Hold d_req, with d_wr=1, d_addr=0x1234, d_wdata=0xBEEF -> mem_wr=1, mem_addr=0x1234, mem_wdata=0xBEEF; i_req=1 throughout -> i_stall=1 and i_gnt=0.
REQ-023 Assert mem_stall=1 in IDLE with i_req=1 for 3 cycles -> no grant; release -> i_gnt=1 one cycle later.
REQ-024 With owner D, drop d_req, then present mem_rdata=0x5A5A during DRAIN_ST -> d_rdata=0x5A5A and i_rdata=0.
REQ-025 Owner asserts rd=1 and wr=1 together -> mem_wr=1, mem_rd=0.
REQ-026 Pulse rst low mid-OWN_I -> outputs zero within the same cycle; after release, with both reqs asserted -> D is granted.
